// File: rtl/compositor_pkg.sv
// Shared defaults and helpers for the layer compositor family.
package compositor_pkg;

    localparam int DEF_LAYERS    = 8;
    localparam int DEF_COLOR_W   = 8;
    localparam int DEF_TILE_SIZE = 16;
    localparam int COORD_W       = 11;

    localparam logic [7:0] DEF_DEBUG_RGB  = 8'hFC;
    localparam logic [7:0] DEF_TRANSP_RGB = 8'hFF;

    // Index of a layer in the default-sized compositor.
    typedef logic [$clog2(DEF_LAYERS)-1:0] layer_idx_t;

    // Width needed to hold a layer index; never zero, so one-layer builds still elaborate.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_compositor_if.sv
// Pixel-side bundle between the drawers, the compositor and the video output stage.
interface layer_compositor_if
    import compositor_pkg::*;
#(
    parameter int LAYERS  = DEF_LAYERS,
    parameter int COLOR_W = DEF_COLOR_W
) ();

    localparam int IDX_W = idx_width(LAYERS);

    // Pixel stream and per-layer data coming from the drawers
    logic                             pixel_valid;
    logic                             frame_start;
    logic [COORD_W-1:0]               pixel_x;
    logic [COORD_W-1:0]               pixel_y;
    logic [LAYERS-1:0]                draw_req;
    logic [LAYERS-1:0][COLOR_W-1:0]   layer_rgb;
    logic [LAYERS-1:0]                layer_en;
    logic [COLOR_W-1:0]               default_rgb;
    logic                             dev_mode;
    logic                             debug_flag;

    // Composited result going to the video output stage
    logic [COLOR_W-1:0]               rgb_out;
    logic                             rgb_valid;
    logic [IDX_W-1:0]                 top_layer;
    logic                             top_hit;
    logic [LAYERS-1:0]                collision_mask;

    // Pixel source side
    modport master (
        output pixel_valid, frame_start, pixel_x, pixel_y, draw_req,
               layer_rgb, layer_en, default_rgb, dev_mode, debug_flag,
        input  rgb_out, rgb_valid, top_layer, top_hit, collision_mask
    );

    // Compositor side
    modport slave (
        input  pixel_valid, frame_start, pixel_x, pixel_y, draw_req,
               layer_rgb, layer_en, default_rgb, dev_mode, debug_flag,
        output rgb_out, rgb_valid, top_layer, top_hit, collision_mask
    );

endinterface

// File: rtl/layer_compositor_prio_encoder.sv
// Lowest-index-first priority encoder; purely combinational, registered by the parent.
module prio_encoder
    import compositor_pkg::*;
#(
    parameter int LAYERS = DEF_LAYERS
) (
    input  logic [LAYERS-1:0]            req,
    output logic [idx_width(LAYERS)-1:0] idx,
    output logic                         hit
);

    localparam int IDX_W = idx_width(LAYERS);

    // Scan from the lowest-priority end so the lowest set index is the last one written
    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// N-layer priority compositor: 2-stage pipeline with blinking debug tile and per-frame collision report.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int                 LAYERS       = DEF_LAYERS,
    parameter int                 COLOR_W      = DEF_COLOR_W,
    parameter bit                 TRANSP_EN    = 1'b1,
    parameter logic [COLOR_W-1:0] TRANSP_RGB   = COLOR_W'(DEF_TRANSP_RGB),
    parameter int                 REF_LAYER    = 0,
    parameter int                 TILE_SIZE    = DEF_TILE_SIZE,
    parameter int                 DEBUG_TILE_X = 0,
    parameter int                 DEBUG_TILE_Y = 0,
    parameter logic [COLOR_W-1:0] DEBUG_RGB    = COLOR_W'(DEF_DEBUG_RGB),
    parameter int                 BLINK_FRAMES = 16
) (
    input  logic               clk,
    input  logic               reset,
    layer_compositor_if.slave  bus
);

    localparam int IDX_W = idx_width(LAYERS);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
    // Clears the reference layer's own bit so it never reports colliding with itself
    localparam logic [LAYERS-1:0] REF_KEEP = ~(LAYERS'(1) << REF_LAYER);

    // Stage 1 combinational inputs
    logic [LAYERS-1:0] eff_next;
    logic              dbg_next;

    // Stage 1 registers
    logic [LAYERS-1:0]              eff1_reg;
    logic [LAYERS-1:0][COLOR_W-1:0] rgb1_reg;
    logic [COLOR_W-1:0]             def1_reg;
    logic                           dbg1_reg;
    logic                           valid1_reg;
    logic                           fs1_reg;

    // Blink state
    logic [BLK_W-1:0] blink_cnt_reg;
    logic             blink_on_reg;

    // Stage 2 signals
    logic [IDX_W-1:0]   win_idx;
    logic               win_hit;
    logic [COLOR_W-1:0] rgb_next;
    logic [LAYERS-1:0]  contrib;
    logic [LAYERS-1:0]  acc_next;
    logic [LAYERS-1:0]  mask_next;

    logic [COLOR_W-1:0] rgb_out_reg;
    logic               rgb_valid_reg;
    logic [IDX_W-1:0]   top_layer_reg;
    logic               top_hit_reg;
    logic [LAYERS-1:0]  acc_reg;
    logic [LAYERS-1:0]  mask_reg;

    // A layer draws only if requested, enabled, in active video and not keyed transparent
    generate
        for (genvar gi = 0; gi < LAYERS; gi++) begin : g_eff
            assign eff_next[gi] = bus.draw_req[gi] & bus.layer_en[gi] & bus.pixel_valid &
                                  !(TRANSP_EN && (bus.layer_rgb[gi] == TRANSP_RGB));
        end
    endgenerate

    // Debug tile qualifier: plain tile-grid position test combined with the mode bits
    assign dbg_next = bus.dev_mode & bus.debug_flag &
                      (int'(bus.pixel_x) / TILE_SIZE == DEBUG_TILE_X) &
                      (int'(bus.pixel_y) / TILE_SIZE == DEBUG_TILE_Y);

    // Stage 1 pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            eff1_reg   <= '0;
            rgb1_reg   <= '0;
            def1_reg   <= '0;
            dbg1_reg   <= 1'b0;
            valid1_reg <= 1'b0;
            fs1_reg    <= 1'b0;
        end else begin
            eff1_reg   <= eff_next;
            rgb1_reg   <= bus.layer_rgb;
            def1_reg   <= bus.default_rgb;
            dbg1_reg   <= dbg_next;
            valid1_reg <= bus.pixel_valid;
            fs1_reg    <= bus.frame_start;
        end
    end

    // Blink phase advances as frame_start enters stage 1, so the first pixel of a frame already sees the new phase
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_reg <= '0;
            blink_on_reg  <= 1'b1;
        end else if (bus.frame_start) begin
            if (blink_cnt_reg == BLK_LAST) begin
                blink_cnt_reg <= '0;
                blink_on_reg  <= ~blink_on_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
        end
    end

    prio_encoder #(
        .LAYERS (LAYERS)
    ) u_prio (
        .req (eff1_reg),
        .idx (win_idx),
        .hit (win_hit)
    );

    // Colour select: blanking beats debug, debug beats layers, layers beat background
    always_comb begin
        rgb_next = '0;
        if (!valid1_reg) begin
            rgb_next = '0;
        end else if (dbg1_reg && blink_on_reg) begin
            rgb_next = DEBUG_RGB;
        end else if (win_hit) begin
            rgb_next = rgb1_reg[win_idx];
        end else begin
            rgb_next = def1_reg;
        end
    end

    // Collision accumulate/snapshot: a frame_start pixel opens the new frame, so its overlap goes to the fresh accumulator
    always_comb begin
        contrib   = eff1_reg[REF_LAYER] ? (eff1_reg & REF_KEEP) : '0;
        acc_next  = acc_reg | contrib;
        mask_next = mask_reg;
        if (fs1_reg) begin
            mask_next = acc_reg;
            acc_next  = contrib;
        end
    end

    // Stage 2 output and collision registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_out_reg   <= '0;
            rgb_valid_reg <= 1'b0;
            top_layer_reg <= '0;
            top_hit_reg   <= 1'b0;
            acc_reg       <= '0;
            mask_reg      <= '0;
        end else begin
            rgb_out_reg   <= rgb_next;
            rgb_valid_reg <= valid1_reg;
            top_layer_reg <= win_idx;
            top_hit_reg   <= win_hit;
            acc_reg       <= acc_next;
            mask_reg      <= mask_next;
        end
    end

    assign bus.rgb_out        = rgb_out_reg;
    assign bus.rgb_valid      = rgb_valid_reg;
    assign bus.top_layer      = top_layer_reg;
    assign bus.top_hit        = top_hit_reg;
    assign bus.collision_mask = mask_reg;

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: a spec-level model predicts each pixel's outputs two cycles ahead.
module tb_layer_compositor;
    import compositor_pkg::*;

    localparam int BLINK_TB = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    layer_compositor_if #(.LAYERS(8), .COLOR_W(8)) bus ();

    layer_compositor #(
        .LAYERS       (8),
        .COLOR_W      (8),
        .BLINK_FRAMES (BLINK_TB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] rgb;
        logic       valid;
        layer_idx_t layer;
        logic       hit;
        logic [7:0] mask;
    } out_t;

    typedef struct {
        int unsigned due;
        out_t        exp;
        string       name;
    } sb_t;

    sb_t sb[$];

    // Static configuration applied by the next drive()
    logic [7:0]      cfg_en;
    logic [7:0]      cfg_def;
    logic [7:0][7:0] cfg_rgb;
    logic            cfg_dev;
    logic            cfg_flag;

    // Model state
    logic [7:0] m_acc;
    logic [7:0] m_mask;
    int         m_cnt;
    logic       m_blink;

    int unsigned cycle_cnt = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Compare DUT outputs against the scoreboard entry due this cycle
    always @(negedge clk) begin
        out_t act;
        sb_t  e;
        act = {bus.rgb_out, bus.rgb_valid, bus.top_layer, bus.top_hit, bus.collision_mask};
        while (sb.size() > 0 && sb[0].due < cycle_cnt) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: no output observed at cycle %0d, required one", e.name, e.due);
        end
        if (sb.size() > 0 && sb[0].due == cycle_cnt) begin
            e = sb.pop_front();
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got rgb=%h v=%b layer=%0d hit=%b mask=%b, expected rgb=%h v=%b layer=%0d hit=%b mask=%b",
                         e.name, act.rgb, act.valid, act.layer, act.hit, act.mask,
                         e.exp.rgb, e.exp.valid, e.exp.layer, e.exp.hit, e.exp.mask);
            end else begin
                $display("txn %s: rgb=%h v=%b layer=%0d hit=%b mask=%b ok",
                         e.name, act.rgb, act.valid, act.layer, act.hit, act.mask);
            end
        end
    end

    task automatic model_reset();
        m_acc   = 8'h00;
        m_mask  = 8'h00;
        m_cnt   = 0;
        m_blink = 1'b1;
    endtask

    task automatic bus_idle();
        bus.pixel_valid = 1'b0;
        bus.frame_start = 1'b0;
        bus.pixel_x     = '0;
        bus.pixel_y     = '0;
        bus.draw_req    = '0;
        bus.layer_en    = cfg_en;
        bus.layer_rgb   = cfg_rgb;
        bus.default_rgb = cfg_def;
        bus.dev_mode    = cfg_dev;
        bus.debug_flag  = cfg_flag;
    endtask

    // Drive one pixel for the next clock and push its predicted outputs
    task automatic drive(input string tag, input logic v, input logic fs,
                         input logic [10:0] x, input logic [10:0] y, input logic [7:0] req);
        sb_t        e;
        logic [7:0] eff;
        logic [7:0] contrib;
        int         win;
        @(posedge clk);
        #1;
        bus.pixel_valid = v;
        bus.frame_start = fs;
        bus.pixel_x     = x;
        bus.pixel_y     = y;
        bus.draw_req    = req;
        bus.layer_en    = cfg_en;
        bus.layer_rgb   = cfg_rgb;
        bus.default_rgb = cfg_def;
        bus.dev_mode    = cfg_dev;
        bus.debug_flag  = cfg_flag;

        if (fs) begin
            if (m_cnt == BLINK_TB - 1) begin
                m_cnt   = 0;
                m_blink = ~m_blink;
            end else begin
                m_cnt++;
            end
        end
        for (int i = 0; i < 8; i++)
            eff[i] = req[i] & cfg_en[i] & v & (cfg_rgb[i] != 8'hFF);
        win = -1;
        for (int i = 7; i >= 0; i--)
            if (eff[i]) win = i;

        e.exp.valid = v;
        e.exp.hit   = (win >= 0);
        e.exp.layer = (win >= 0) ? layer_idx_t'(win) : layer_idx_t'(0);
        if (!v)
            e.exp.rgb = 8'h00;
        else if (cfg_dev && cfg_flag && x < 16 && y < 16 && m_blink)
            e.exp.rgb = 8'hFC;
        else if (win >= 0)
            e.exp.rgb = cfg_rgb[win];
        else
            e.exp.rgb = cfg_def;

        contrib = eff[0] ? (eff & 8'hFE) : 8'h00;
        if (fs) begin
            m_mask = m_acc;
            m_acc  = contrib;
        end else begin
            m_acc = m_acc | contrib;
        end
        e.exp.mask = m_mask;
        e.due      = cycle_cnt + 2;
        e.name     = tag;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) drive("idle", 1'b0, 1'b0, 11'd0, 11'd0, 8'h00);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        bus_idle();
        sb.delete();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.rgb_out !== 8'h00) begin errors++; $display("FAIL reset_rgb_out: got %h expected 00", bus.rgb_out); end
        checks++;
        if (bus.rgb_valid !== 1'b0) begin errors++; $display("FAIL reset_rgb_valid: got %b expected 0", bus.rgb_valid); end
        checks++;
        if (bus.top_layer !== 3'd0) begin errors++; $display("FAIL reset_top_layer: got %0d expected 0", bus.top_layer); end
        checks++;
        if (bus.top_hit !== 1'b0) begin errors++; $display("FAIL reset_top_hit: got %b expected 0", bus.top_hit); end
        checks++;
        if (bus.collision_mask !== 8'h00) begin errors++; $display("FAIL reset_mask: got %b expected 0", bus.collision_mask); end
        $display("txn reset: outputs rgb=%h v=%b layer=%0d hit=%b mask=%b",
                 bus.rgb_out, bus.rgb_valid, bus.top_layer, bus.top_hit, bus.collision_mask);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_priority();
        cfg_dev = 1'b0; cfg_flag = 1'b0;
        cfg_en  = 8'hFF; cfg_def = 8'h5A;
        cfg_rgb = '0;
        cfg_rgb[1] = 8'h1C;
        cfg_rgb[3] = 8'hE0;
        drive("prio_1_over_3", 1'b1, 1'b0, 11'd100, 11'd100, 8'b0000_1010);
        drive("prio_3_only",   1'b1, 1'b0, 11'd101, 11'd100, 8'b0000_1000);
        drive("prio_none",     1'b1, 1'b0, 11'd102, 11'd100, 8'b0000_0000);
        idle(2);
    endtask

    task automatic test_transparency();
        cfg_rgb = {8'h70, 8'h60, 8'h03, 8'h40, 8'hE0, 8'h20, 8'hFF, 8'h11};
        cfg_en  = 8'b1111_0111;
        cfg_def = 8'h00;
        drive("transp_layer5", 1'b1, 1'b0, 11'd200, 11'd50, 8'b0010_1010);
        drive("transp_none",   1'b1, 1'b0, 11'd201, 11'd50, 8'b0000_0000);
        cfg_def = 8'h92;
        drive("transp_def",    1'b1, 1'b0, 11'd202, 11'd50, 8'b0000_1010);
        drive("invalid_pix",   1'b0, 1'b0, 11'd203, 11'd50, 8'b0010_0001);
        cfg_en = 8'hFF;
        idle(2);
    endtask

    task automatic test_debug_blink();
        cfg_rgb = {8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h44, 8'h20, 8'h11};
        cfg_dev = 1'b1; cfg_flag = 1'b1; cfg_def = 8'h09;
        drive("dbg_f0_in",  1'b1, 1'b0, 11'd5,  11'd5, 8'b0000_0100);
        drive("dbg_f0_out", 1'b1, 1'b0, 11'd40, 11'd5, 8'b0000_0100);
        for (int f = 1; f <= 5; f++) begin
            drive($sformatf("dbg_f%0d_fs", f), 1'b1, 1'b1, 11'd5, 11'd5, 8'b0000_0100);
            drive($sformatf("dbg_f%0d_in", f), 1'b1, 1'b0, 11'd15, 11'd15, 8'b0000_0000);
            drive($sformatf("dbg_f%0d_out", f), 1'b1, 1'b0, 11'd16, 11'd5, 8'b0000_0100);
        end
        cfg_flag = 1'b0;
        for (int f = 0; f < 3; f++) begin
            drive($sformatf("noflag_f%0d_fs", f), 1'b1, 1'b1, 11'd5, 11'd5, 8'b0000_0100);
            drive($sformatf("noflag_f%0d_in", f), 1'b1, 1'b0, 11'd5, 11'd5, 8'b0000_0000);
        end
        cfg_dev = 1'b0;
        idle(2);
    endtask

    task automatic test_collision();
        cfg_rgb = {8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h44, 8'h20, 8'h11};
        cfg_en  = 8'hFF; cfg_dev = 1'b0; cfg_flag = 1'b0;
        drive("col_fsN",      1'b1, 1'b1, 11'd0, 11'd0, 8'b0000_0000);
        drive("col_ref_l4",   1'b1, 1'b0, 11'd1, 11'd0, 8'b0001_0001);
        drive("col_l2_alone", 1'b1, 1'b0, 11'd2, 11'd0, 8'b0000_0100);
        drive("col_fsN1",     1'b1, 1'b1, 11'd0, 11'd0, 8'b0000_0000);
        drive("col_clean",    1'b1, 1'b0, 11'd1, 11'd0, 8'b0000_0001);
        drive("col_fsN2",     1'b1, 1'b1, 11'd0, 11'd0, 8'b0000_1001);
        drive("col_after_fs", 1'b1, 1'b0, 11'd1, 11'd0, 8'b0000_0010);
        drive("col_fsN3",     1'b0, 1'b1, 11'd0, 11'd0, 8'b0000_0000);
        drive("col_fsN4",     1'b0, 1'b1, 11'd0, 11'd0, 8'b0000_0000);
        idle(2);
    endtask

    task automatic test_reset_midframe();
        cfg_dev = 1'b1; cfg_flag = 1'b1;
        drive("rst_fs_a",    1'b1, 1'b1, 11'd5, 11'd5, 8'b0000_0000);
        drive("rst_fs_b",    1'b1, 1'b1, 11'd5, 11'd5, 8'b0000_0000);
        drive("rst_overlap", 1'b1, 1'b0, 11'd6, 11'd5, 8'b0100_0001);
        drive("rst_inflight",1'b1, 1'b0, 11'd7, 11'd5, 8'b0010_0001);
        test_reset();
        drive("post_rst_dbg", 1'b1, 1'b0, 11'd5, 11'd5, 8'b0000_0000);
        drive("post_rst_fs",  1'b1, 1'b1, 11'd5, 11'd5, 8'b0000_0000);
        drive("post_rst_fs2", 1'b1, 1'b1, 11'd60, 11'd5, 8'b0000_0000);
        cfg_dev = 1'b0; cfg_flag = 1'b0;
        idle(2);
    endtask

    task automatic test_back_to_back();
        cfg_dev = 1'b1; cfg_flag = 1'b1;
        for (int n = 0; n < 40; n++) begin
            drive($sformatf("b2b_%0d", n), ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
                  11'($urandom_range(0, 40)), 11'($urandom_range(0, 40)), 8'($urandom));
        end
        idle(3);
    endtask

    // Bound the whole run in case the sequence stalls
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cfg_en = 8'hFF; cfg_def = 8'h00; cfg_rgb = '0; cfg_dev = 1'b0; cfg_flag = 1'b0;
        bus_idle();
        model_reset();
        test_reset();
        test_priority();
        test_transparency();
        test_reset();
        test_debug_blink();
        test_collision();
        test_reset_midframe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
